alu_exec_stage: RTL
===================

# alu_exec_stage

Pipelined execute stage wrapping the combinational `ALU`. It accepts operand/opcode bundles from decode over a valid/ready handshake and registers them. It presents them to the `ALU`, registers the result and flags for writeback, and maintains the architectural condition-code register (CCR) plus sticky error flags. Throughput is one operation per cycle with full backpressure.

## Interface
- No parameters; data width is fixed at 8 and opcode width at 4.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: decode offers an operation.
- `in_ready` out 1: stage can accept this cycle.
- `in_a` in 8: operand A.
- `in_b` in 8: operand B.
- `in_sel` in 4: ALU opcode, 0000–1001 legal.
- `in_ccr_we` in 1: operation updates CCR on completion.
- `in_fwd_a`, `in_fwd_b` in 1 each: forward last result into A/B (present only with `ALU_FWD_EN`).
- `out_valid` out 1: result available.
- `out_ready` in 1: writeback accepts result.
- `out_result` out 8: registered result.
- `out_nzvc` out 4: registered flags {N,Z,V,C}.
- `ccr` out 4: architectural CCR {N,Z,V,C}.
- `div0_err` out 1: sticky, divide/modulo by zero seen.
- `illegal_op` out 1: sticky, opcode 1010–1111 seen.
- `err_clr` in 1: clears both sticky flags.

## Operation
- Two registered stages.
  - S1 holds operands, sel, ccr_we and fwd bits, with `s1_valid`.
  - S2 holds result and flags, with `out_valid`.
- The ALU input is driven combinationally from S1, after the forward mux.
- Handshake:
  - `in_ready = !s1_valid || s1_adv`.
  - `s1_adv = s1_valid && (!out_valid || out_ready)`.
  - S2 loads on `s1_adv`; `out_valid` clears on `out_ready` when there is no new load.
- Output stability: `out_result` and `out_nzvc` hold stable while `out_valid && !out_ready`.
- Result masking, applied before S2 load:
  - Sel 0100 with B≠0: V=0, C=0.
  - Illegal sel: result 8'h00, nzvc 4'b0000, no CCR write.
  - B=0 on sel 0011/0100: pass the ALU error encoding (result 8'hFF, nzvc 4'b1111).
- CCR: on `s1_adv` with `ccr_we` and a legal opcode, `ccr <= masked nzvc`. This happens the same edge as the S2 load, independent of `out_ready`.
- Sticky errors:
  - `div0_err` sets on `s1_adv` with sel 0011/0100 and effective B=0.
  - `illegal_op` sets on `s1_adv` with sel ≥ 1010.
  - `err_clr` clears both; a set in the same cycle wins over clear.
- Reset values:
  - `s1_valid`=0, `out_valid`=0, `in_ready`=1 after reset.
  - `out_result`=8'h00, `out_nzvc`=0, `ccr`=0, `div0_err`=0, `illegal_op`=0, `last_result`=8'h00.
- Reset mid-operation: in-flight S1 and S2 contents are discarded; no CCR update occurs on the reset edge.

## Timing
- Latency: an op accepted at edge k appears on `out_valid` after edge k+1.
- Throughput: back-to-back acceptance while `out_ready`=1.
- Full stall: with `out_ready` low and S1 and S2 both full, `in_ready`=0.
- Stall release: `out_ready` rising gives `in_ready`=1 in the same cycle. The skid is combinational through `out_ready`.
- Empty pipe: S1 empty and S2 full with `out_ready`=0 still accepts one op into S1.

## Configuration
- Macro `ALU_FWD_EN`.
- Defined:
  - Register `last_result` is loaded with the masked result on every S2 load.
  - S1 operand A/B is replaced by `last_result` at the ALU input when the matching fwd bit is set.
  - A dependent op issued the cycle after its producer sees the producer's result.
- Undefined:
  - The `in_fwd_a`/`in_fwd_b` ports and `last_result` are absent.
  - Operands always come from `in_a`/`in_b`.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (OP_ADD=4'h0 … OP_XOR=4'h9);
  - NZVC bit indices (N=3, Z=2, V=1, C=0);
  - `is_legal_op` and `is_div_op` functions.
- One sub-module: the existing combinational `ALU`, instantiated once between S1 and S2. No other hierarchy.

## Test plan
- ADD A=8'h7F, B=8'h01, ccr_we=1, out_ready=1 -> after 2 edges: result 8'h80, nzvc 1010, ccr 1010.
- DIV A=8'h10, B=8'h00 -> result 8'hFF, nzvc 1111, `div0_err`=1 and stays 1 until `err_clr`.
- sel 4'hC -> result 8'h00, nzvc 0000, `illegal_op`=1, ccr unchanged.
- Backpressure: three SUBs issued with `out_ready`=0 -> `in_ready` drops after the second. Releasing `out_ready` delivers all three in order with no loss or duplication.
- Reset asserted with both stages full -> next cycle `out_valid`=0, ccr=0, `in_ready`=1; the later first op completes normally.
- `ALU_FWD_EN`: ADD 8'h03+8'h04, then AND with fwd_a=1 and B=8'h06 issued the next cycle -> second result 8'h06.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute stage and its combinational ALU:
//   - datapath/opcode widths (data fixed at 8 bits, opcode at 4 bits)
//   - opcode encodings OP_ADD (4'h0) .. OP_XOR (4'h9); 4'hA..4'hF are illegal
//   - bit positions inside the {N,Z,V,C} flag nibble
//   - alu_out_t result/flag bundle
//   - is_legal_op / is_div_op opcode classifiers
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'h0;
   localparam logic [OP_W-1:0] OP_SUB = 4'h1;
   localparam logic [OP_W-1:0] OP_MUL = 4'h2;
   localparam logic [OP_W-1:0] OP_DIV = 4'h3;
   localparam logic [OP_W-1:0] OP_MOD = 4'h4;
   localparam logic [OP_W-1:0] OP_AND = 4'h5;
   localparam logic [OP_W-1:0] OP_OR  = 4'h6;
   localparam logic [OP_W-1:0] OP_SHL = 4'h7;
   localparam logic [OP_W-1:0] OP_SHR = 4'h8;
   localparam logic [OP_W-1:0] OP_XOR = 4'h9;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int V_BIT = 1;
   localparam int C_BIT = 0;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [3:0]        nzvc;
   } alu_out_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] sel);
      return (sel <= OP_XOR);
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] sel);
      return (sel == OP_DIV) || (sel == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_if
// Bundles the decode-side and writeback-side handshakes plus the architectural
// status outputs of alu_exec_stage.
//   slave  : the execute stage itself
//   master : decode/writeback environment driving it
// Signals: in_valid/in_ready, in_a, in_b, in_sel, in_ccr_we,
//          in_fwd_a/in_fwd_b (only with ALU_FWD_EN), out_valid/out_ready,
//          out_result, out_nzvc, ccr, div0_err, illegal_op, err_clr.
// Optional feature macro: ALU_FWD_EN (adds the forwarding request bits).
// -----------------------------------------------------------------------------
interface alu_exec_stage_if;

   logic                        in_valid;
   logic                        in_ready;
   logic [alu_pkg::DATA_W-1:0]  in_a;
   logic [alu_pkg::DATA_W-1:0]  in_b;
   logic [alu_pkg::OP_W-1:0]    in_sel;
   logic                        in_ccr_we;
`ifdef ALU_FWD_EN
   logic                        in_fwd_a;
   logic                        in_fwd_b;
`endif
   logic                        out_valid;
   logic                        out_ready;
   logic [alu_pkg::DATA_W-1:0]  out_result;
   logic [3:0]                  out_nzvc;
   logic [3:0]                  ccr;
   logic                        div0_err;
   logic                        illegal_op;
   logic                        err_clr;

   modport slave (
      input  in_valid, in_a, in_b, in_sel, in_ccr_we,
`ifdef ALU_FWD_EN
      input  in_fwd_a, in_fwd_b,
`endif
      input  out_ready, err_clr,
      output in_ready, out_valid, out_result, out_nzvc, ccr, div0_err, illegal_op
   );

   modport master (
      output in_valid, in_a, in_b, in_sel, in_ccr_we,
`ifdef ALU_FWD_EN
      output in_fwd_a, in_fwd_b,
`endif
      output out_ready, err_clr,
      input  in_ready, out_valid, out_result, out_nzvc, ccr, div0_err, illegal_op
   );

endinterface

// File: rtl/alu_exec_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational 8-bit ALU.
//   a, b   in  8 : operands
//   sel    in  4 : opcode (see alu_pkg); illegal opcodes give result 0
//   result out 8 : operation result
//   nzvc   out 4 : {N,Z,V,C}
// Divide/modulo by zero returns the error encoding result 8'hFF, nzvc 4'hF.
// SUB carry is the borrow (a < b unsigned). MUL carry flags a non-zero upper
// byte. MOD carry flags a non-zero remainder. Shifts are by one bit and
// carry out the shifted-off bit.
// -----------------------------------------------------------------------------
module alu
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   sel,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        nzvc
);

   logic [DATA_W:0]          sum;
   logic [2*DATA_W-1:0]      prod;
   logic signed [DATA_W-1:0] sa;
   logic signed [DATA_W-1:0] sb;
   logic signed [DATA_W-1:0] sr;
   logic                     v;
   logic                     c;
   logic                     err;

   always_comb begin
      sum    = '0;
      prod   = '0;
      result = '0;
      v      = 1'b0;
      c      = 1'b0;
      err    = 1'b0;
      sa     = signed'(a);
      sb     = signed'(b);
      unique case (sel)
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[DATA_W-1:0];
            c      = sum[DATA_W];
         end
         OP_SUB: begin
            sum    = {1'b0, a} - {1'b0, b};
            result = sum[DATA_W-1:0];
            c      = sum[DATA_W];
         end
         OP_MUL: begin
            prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            result = prod[DATA_W-1:0];
            c      = |prod[2*DATA_W-1:DATA_W];
         end
         OP_DIV: begin
            if (b == '0) err = 1'b1;
            else         result = a / b;
         end
         OP_MOD: begin
            if (b == '0) err = 1'b1;
            else begin
               result = a % b;
               c      = (result != '0);
            end
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            c      = a[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DATA_W-1:1]};
            c      = a[0];
         end
         OP_XOR: result = a ^ b;
         default: result = '0;
      endcase

      sr = signed'(result);
      // Signed overflow: operand signs agree (ADD) or differ (SUB) and the
      // result sign departs from A.
      if (sel == OP_ADD)
         v = ((sa < 8'sd0) == (sb < 8'sd0)) && ((sr < 8'sd0) != (sa < 8'sd0));
      else if (sel == OP_SUB)
         v = ((sa < 8'sd0) != (sb < 8'sd0)) && ((sr < 8'sd0) != (sa < 8'sd0));

      nzvc        = '0;
      nzvc[N_BIT] = result[DATA_W-1];
      nzvc[Z_BIT] = (result == '0);
      nzvc[V_BIT] = v;
      nzvc[C_BIT] = c;
      if (err) begin
         result = '1;
         nzvc   = 4'hF;
      end
   end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Two-stage pipelined execute stage around the combinational alu.
//   clock in : rising-edge clock
//   reset in : synchronous, active-low
//   bus       : alu_exec_stage_if.slave
//     in_valid/in_ready, in_a, in_b, in_sel, in_ccr_we (+ in_fwd_a/b)
//     out_valid/out_ready, out_result, out_nzvc
//     ccr (architectural {N,Z,V,C}), div0_err, illegal_op, err_clr
// S1 registers the decoded operation; the alu runs from S1; S2 registers the
// masked result for writeback. One op per cycle with full backpressure; the
// S1 skid is combinational through out_ready.
// Optional feature macro: ALU_FWD_EN (forward last result into A/B).
// -----------------------------------------------------------------------------
module alu_exec_stage
   import alu_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   alu_exec_stage_if.slave  bus
);

   logic              vld_p1_q, vld_p1_d;
   logic [DATA_W-1:0] a_p1_q, a_p1_d;
   logic [DATA_W-1:0] b_p1_q, b_p1_d;
   logic [OP_W-1:0]   sel_p1_q, sel_p1_d;
   logic              ccr_we_p1_q, ccr_we_p1_d;
`ifdef ALU_FWD_EN
   logic              fwd_a_p1_q, fwd_a_p1_d;
   logic              fwd_b_p1_q, fwd_b_p1_d;
   logic [DATA_W-1:0] last_result_q, last_result_d;
`endif
   logic              vld_p2_q, vld_p2_d;
   logic [DATA_W-1:0] result_p2_q, result_p2_d;
   logic [3:0]        nzvc_p2_q, nzvc_p2_d;
   logic [3:0]        ccr_q, ccr_d;
   logic              div0_q, div0_d;
   logic              illegal_q, illegal_d;

   logic              s1_adv;
   logic              in_ready;
   logic              accept;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_nzvc;
   alu_out_t          masked;

   // Illegal opcodes are squashed to zero; MOD with a real divisor never
   // reports V/C. Divide-by-zero keeps the alu error encoding untouched.
   function automatic alu_out_t mask_alu_out(input logic [OP_W-1:0]   sel,
                                             input logic [DATA_W-1:0] b,
                                             input alu_out_t          raw);
      alu_out_t m;
      m = raw;
      if (!is_legal_op(sel)) begin
         m.result = '0;
         m.nzvc   = '0;
      end else if ((sel == OP_MOD) && (b != '0)) begin
         m.nzvc[V_BIT] = 1'b0;
         m.nzvc[C_BIT] = 1'b0;
      end
      return m;
   endfunction

   // ---- S1 -> alu: operand select (forward mux) ----
   always_comb begin
      alu_a = a_p1_q;
      alu_b = b_p1_q;
`ifdef ALU_FWD_EN
      if (fwd_a_p1_q) alu_a = last_result_q;
      if (fwd_b_p1_q) alu_b = last_result_q;
`endif
   end

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .sel    (sel_p1_q),
      .result (alu_res),
      .nzvc   (alu_nzvc)
   );

   always_comb begin
      s1_adv   = vld_p1_q && (!vld_p2_q || bus.out_ready);
      in_ready = !vld_p1_q || s1_adv;
      accept   = bus.in_valid && in_ready;
      masked   = mask_alu_out(sel_p1_q, alu_b, '{result: alu_res, nzvc: alu_nzvc});

      vld_p1_d    = vld_p1_q;
      a_p1_d      = a_p1_q;
      b_p1_d      = b_p1_q;
      sel_p1_d    = sel_p1_q;
      ccr_we_p1_d = ccr_we_p1_q;
`ifdef ALU_FWD_EN
      fwd_a_p1_d    = fwd_a_p1_q;
      fwd_b_p1_d    = fwd_b_p1_q;
      last_result_d = last_result_q;
`endif
      if (s1_adv) vld_p1_d = 1'b0;
      if (accept) begin
         vld_p1_d    = 1'b1;
         a_p1_d      = bus.in_a;
         b_p1_d      = bus.in_b;
         sel_p1_d    = bus.in_sel;
         ccr_we_p1_d = bus.in_ccr_we;
`ifdef ALU_FWD_EN
         fwd_a_p1_d  = bus.in_fwd_a;
         fwd_b_p1_d  = bus.in_fwd_b;
`endif
      end

      vld_p2_d    = vld_p2_q;
      result_p2_d = result_p2_q;
      nzvc_p2_d   = nzvc_p2_q;
      ccr_d       = ccr_q;
      if (bus.out_ready) vld_p2_d = 1'b0;
      if (s1_adv) begin
         vld_p2_d    = 1'b1;
         result_p2_d = masked.result;
         nzvc_p2_d   = masked.nzvc;
`ifdef ALU_FWD_EN
         last_result_d = masked.result;
`endif
         if (ccr_we_p1_q && is_legal_op(sel_p1_q)) ccr_d = masked.nzvc;
      end

      // A set in the same cycle as err_clr wins.
      div0_d    = (s1_adv && is_div_op(sel_p1_q) && (alu_b == '0)) ||
                  (div0_q && !bus.err_clr);
      illegal_d = (s1_adv && !is_legal_op(sel_p1_q)) ||
                  (illegal_q && !bus.err_clr);
   end

   // ---- decode -> S1 ----
   always_ff @(posedge clock) begin
      a_p1_d_unused_guard: begin
         a_p1_q      <= a_p1_d;
         b_p1_q      <= b_p1_d;
         sel_p1_q    <= sel_p1_d;
         ccr_we_p1_q <= ccr_we_p1_d;
`ifdef ALU_FWD_EN
         fwd_a_p1_q  <= fwd_a_p1_d;
         fwd_b_p1_q  <= fwd_b_p1_d;
`endif
      end
   end

   // ---- S1 -> S2, control and architectural state ----
   always_ff @(posedge clock) begin
      if (!reset) begin
         vld_p1_q      <= 1'b0;
         vld_p2_q      <= 1'b0;
         result_p2_q   <= '0;
         nzvc_p2_q     <= '0;
         ccr_q         <= '0;
         div0_q        <= 1'b0;
         illegal_q     <= 1'b0;
`ifdef ALU_FWD_EN
         last_result_q <= '0;
`endif
      end else begin
         vld_p1_q      <= vld_p1_d;
         vld_p2_q      <= vld_p2_d;
         result_p2_q   <= result_p2_d;
         nzvc_p2_q     <= nzvc_p2_d;
         ccr_q         <= ccr_d;
         div0_q        <= div0_d;
         illegal_q     <= illegal_d;
`ifdef ALU_FWD_EN
         last_result_q <= last_result_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = vld_p2_q;
   assign bus.out_result = result_p2_q;
   assign bus.out_nzvc   = nzvc_p2_q;
   assign bus.ccr        = ccr_q;
   assign bus.div0_err   = div0_q;
   assign bus.illegal_op = illegal_q;

endmodule
